// File: rtl/filt_ctrl_pkg.sv
// Shared types/constants for the filter-section sequencer.
// Optional macro FILT_SETTLE_EN adds two settle states.
package filt_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLR1,
    MAC1,
    LDF,
    CLR2,
    MAC2,
    LDY,
`ifdef FILT_SETTLE_EN
    SHF,
    SETTLE_F,
    SETTLE_Y
`else
    SHF
`endif
  } state_t;

  localparam int SEL_U    = 0;
  localparam int SEL_F1_A = 1;
  localparam int SEL_F2_A = 2;
  localparam int SEL_F    = 3;
  localparam int SEL_F1_B = 4;
  localparam int SEL_F2_B = 5;

  // cycles from the accepting edge to the done cycle
  function automatic int filt_latency(input int n);
`ifdef FILT_SETTLE_EN
    return 2 * n + 7;
`else
    return 2 * n + 5;
`endif
  endfunction

  localparam int FILT_LATENCY = filt_latency(3);

endpackage

// File: rtl/filtro_secuenciador.sv
// Per-sample DF-II control sequencer for one filter section.
// Macro FILT_SETTLE_EN inserts settle cycles after LDF and MAC2.
module filtro_secuenciador
  import filt_ctrl_pkg::*;
#(
  parameter int N_TAPS = 3,
  parameter int SEL_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr_ovr,
  output logic [SEL_W-1:0] sel,
  output logic             rst_acum,
  output logic             leer,
  output logic             desp,
  output logic             leer_y,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int CNT_W =
    (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_TAPS - 1);

  if (N_TAPS < 1) begin : g_bad_taps
    $error("N_TAPS must be at least 1");
  end
  if (2 * N_TAPS > (1 << SEL_W)) begin : g_bad_sel
    $error("SEL_W too narrow for 2*N_TAPS selects");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] sel_n;
  logic             rst_acum_n;
  logic             leer_n;
  logic             desp_n;
  logic             leer_y_n;
  logic             busy_n;
  logic             done_n;
  logic             ovr_n;

  // next state and tap counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (start) state_n = CLR1;
      CLR1: begin
        state_n = MAC1;
        cnt_n   = '0;
      end
      MAC1: begin
        if (cnt == LAST) state_n = LDF;
        else cnt_n = cnt + CNT_W'(1);
      end
`ifdef FILT_SETTLE_EN
      LDF:      state_n = SETTLE_F;
      SETTLE_F: state_n = CLR2;
`else
      LDF:      state_n = CLR2;
`endif
      CLR2: begin
        state_n = MAC2;
        cnt_n   = '0;
      end
      MAC2: begin
`ifdef FILT_SETTLE_EN
        if (cnt == LAST) state_n = SETTLE_Y;
`else
        if (cnt == LAST) state_n = LDY;
`endif
        else cnt_n = cnt + CNT_W'(1);
      end
`ifdef FILT_SETTLE_EN
      SETTLE_Y: state_n = LDY;
`endif
      LDY:     state_n = SHF;
      SHF:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs decoded from the upcoming state/counter
  always_comb begin
    sel_n      = sel;
    rst_acum_n = 1'b0;
    leer_n     = 1'b0;
    desp_n     = 1'b0;
    leer_y_n   = 1'b0;
    done_n     = 1'b0;
    busy_n     = (state_n != IDLE);
    unique case (state_n)
      IDLE: sel_n = '0;
      CLR1: begin
        rst_acum_n = 1'b1;
        sel_n      = SEL_W'(SEL_U);
      end
      MAC1: sel_n = SEL_W'(cnt_n);
      LDF:  leer_n = 1'b1;
      CLR2: begin
        rst_acum_n = 1'b1;
        sel_n      = SEL_W'(N_TAPS);
      end
      MAC2: sel_n = SEL_W'(N_TAPS) + SEL_W'(cnt_n);
      LDY:  leer_y_n = 1'b1;
      SHF: begin
        desp_n = 1'b1;
        done_n = 1'b1;
      end
      default: ;
    endcase
  end

  // sticky overrun; a fresh overrun beats a clear
  always_comb begin
    ovr_n = overrun;
    if (start && busy) ovr_n = 1'b1;
    else if (clr_ovr)  ovr_n = 1'b0;
  end

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= '0;
      rst_acum <= 1'b0;
      leer     <= 1'b0;
      desp     <= 1'b0;
      leer_y   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sel      <= sel_n;
      rst_acum <= rst_acum_n;
      leer     <= leer_n;
      desp     <= desp_n;
      leer_y   <= leer_y_n;
      busy     <= busy_n;
      done     <= done_n;
      overrun  <= ovr_n;
    end
  end

endmodule

// File: tb/tb_filtro_secuenciador.sv
// Scoreboard bench for filtro_secuenciador.
// Honours FILT_SETTLE_EN when the DUT is built with it.
module tb_filtro_secuenciador;

  localparam int N = 3;
  localparam int W = 4;
`ifdef FILT_SETTLE_EN
  localparam bit SETTLE = 1'b1;
`else
  localparam bit SETTLE = 1'b0;
`endif
  localparam int LAT = 2 * N + 5 + (SETTLE ? 2 : 0);

  // strobe vector {rst_acum, leer, leer_y, desp, done}
  localparam logic [4:0] S_CLR  = 5'b10000;
  localparam logic [4:0] S_LEER = 5'b01000;
  localparam logic [4:0] S_LY   = 5'b00100;
  localparam logic [4:0] S_SHF  = 5'b00011;

  typedef struct {
    int         cyc;
    logic [4:0] strb;
    logic [3:0] sel;
    bit         chk_sel;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         clr_ovr = 1'b0;
  logic [W-1:0] sel;
  logic         rst_acum, leer, desp, leer_y;
  logic         busy, done, overrun;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   busy_end = -1;
  int   n_exp_done = 0;
  int   done_seen = 0;
  bit   ovr_model = 1'b0;
  bit   ovr_pending = 1'b0;
  bit   mon_en = 1'b0;

  filtro_secuenciador #(.N_TAPS(N), .SEL_W(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .clr_ovr(clr_ovr), .sel(sel),
    .rst_acum(rst_acum), .leer(leer),
    .desp(desp), .leer_y(leer_y),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fails++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               nm, cyc, act, exp_v);
    end
  endtask

  task automatic push(inout int t, input logic [4:0] s,
                      input int sv, input bit cs);
    exp_t e;
    e.cyc     = t;
    e.strb    = s;
    e.sel     = 4'(sv);
    e.chk_sel = cs;
    q.push_back(e);
    t++;
  endtask

  // expected per-cycle behaviour of one accepted sample
  task automatic model_seq(input int c);
    int t = c + 1;
    push(t, S_CLR, 0, 1);
    for (int k = 0; k < N; k++) push(t, 5'b0, k, 1);
    push(t, S_LEER, N - 1, 1);
    if (SETTLE) push(t, 5'b0, N - 1, 1);
    push(t, S_CLR, N, 1);
    for (int k = 0; k < N; k++) push(t, 5'b0, N + k, 1);
    if (SETTLE) push(t, 5'b0, 0, 0);
    push(t, S_LY, 0, 0);
    push(t, S_SHF, 0, 0);
    n_exp_done++;
  endtask

  // one cycle of stimulus plus reference-model update
  task automatic step(input bit s, input bit c, input bit r);
    int cur;
    @(posedge clk);
    #1;
    ovr_model = ovr_pending;
    cur = cyc;
    start = s;
    clr_ovr = c;
    rst = r;
    if (r) begin
      while (q.size() > 0 && q[$].cyc > cur) begin
        if (q[$].strb[0]) n_exp_done--;
        void'(q.pop_back());
      end
      busy_end = cur;
      ovr_pending = 1'b0;
    end else if (s && cur > busy_end) begin
      model_seq(cur);
      busy_end = cur + LAT;
      ovr_pending = c ? 1'b0 : ovr_model;
    end else if (s) begin
      ovr_pending = 1'b1;
    end else begin
      ovr_pending = c ? 1'b0 : ovr_model;
    end
  endtask

  // monitor: pop and compare whenever the DUT is due to act
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] st;
    if (mon_en) begin
      st = {rst_acum, leer, leer_y, desp, done};
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_step", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("strobes", int'(st), int'(e.strb));
        chk("busy", int'(busy), 1);
        if (e.chk_sel) chk("sel", int'(sel), int'(e.sel));
      end else begin
        chk("idle_strobes", int'(st), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_sel", int'(sel), 0);
      end
      chk("overrun", int'(overrun), int'(ovr_model));
      chk("excl",
          int'($countones({rst_acum, leer, leer_y, desp}) <= 1),
          1);
      if (done) done_seen++;
    end
  end

  initial begin
    int c0;
    bit rs, ss, cs;
    step(0, 0, 1);
    step(0, 0, 1);
    mon_en = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    // single sample
    step(1, 0, 0);
    repeat (LAT + 4) step(0, 0, 0);

    // back-to-back at the earliest accept cycle
    step(1, 0, 0);
    repeat (LAT) step(0, 0, 0);
    step(1, 0, 0);
    repeat (LAT + 4) step(0, 0, 0);

    // overrun at t0+4, clear at t0+20
    c0 = cyc;
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    while (cyc < c0 + 20) step(0, 0, 0);
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);

    // start during SHF sets overrun; clear and start together
    step(1, 0, 0);
    repeat (LAT - 1) step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (LAT + 2) step(0, 1, 0);

    // reset for two cycles mid-MAC1, then a clean sample
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (LAT + 3) step(0, 0, 0);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      rs = ($urandom % 1500) == 0;
      ss = !rs && (($urandom % 6) == 0);
      cs = ($urandom % 40) == 0;
      step(ss, cs, rs);
    end
    repeat (LAT + 4) step(0, 0, 0);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    chk("done_count", done_seen, n_exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
